// File: rtl/e_md_unit_pkg.sv
// Shared codes and types for the E-stage multiply/divide unit.
// No logic; combinational constants only, no latency or flow control.
package e_md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MSUB  = 4'd5,
    MD_MSUBU = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  function automatic logic is_mul_op(input logic [3:0] sel);
    return (sel == MD_MULT) || (sel == MD_MULTU) || (sel == MD_MSUB) || (sel == MD_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] sel);
    return (sel == MD_DIV) || (sel == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_core.sv
// Combinational next-HI/LO datapath for mult/div/msub/mthi/mtlo.
// Zero latency, no flow control; div_zero marks a divide whose result must be dropped.
module e_md_core
  import e_md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  hilo_t       cur,
  input  logic [3:0]  md_sel,
  output hilo_t       res,
  output logic        div_zero
);

  logic signed [63:0] sa, sb;
  logic [63:0] sprod, uprod, cur64;
  logic        b_zero, ovf;
  logic [31:0] sbd, ubd, sq, sr, uq, ur;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};
  assign cur64 = {cur.hi, cur.lo};

  // Dividing INT_MIN by 1 instead of -1 yields the architectural 0x80000000 / 0
  // and keeps the divider away from the overflowing operand pair.
  assign b_zero = (b == 32'd0);
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sbd    = (b_zero || ovf) ? 32'd1 : b;
  assign ubd    = b_zero ? 32'd1 : b;
  assign sq     = $signed(a) / $signed(sbd);
  assign sr     = $signed(a) % $signed(sbd);
  assign uq     = a / ubd;
  assign ur     = a % ubd;

  always_comb begin
    res      = cur;
    div_zero = 1'b0;
    case (md_op_t'(md_sel))
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_MSUB:  res = cur64 - sprod;
      MD_MSUBU: res = cur64 - uprod;
      MD_DIV: begin
        div_zero = b_zero;
        if (!b_zero) res = {sr, sq};
      end
      MD_DIVU: begin
        div_zero = b_zero;
        if (!b_zero) res = {ur, uq};
      end
      MD_MTHI:  res.hi = a;
      MD_MTLO:  res.lo = a;
      default:  res = cur;
    endcase
  end

endmodule

// File: rtl/e_md_unit.sv
// E-stage mult/div sequencer owning HI/LO; mul ops retire MUL_CYCLES, div ops DIV_CYCLES after issue, mthi/mtlo in one edge.
// busy is the only backpressure: a new op is taken in IDLE or on the completing edge, and ignored otherwise.
module e_md_unit
  import e_md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  md_state_t state, next_state;
  logic [3:0] cnt;
  hilo_t      hilo, pend, cur, core_res;
  logic       pend_wr, div_zero;
  logic       is_mul, is_div, is_mt, done, accept;

  assign is_mul = is_mul_op(md_sel);
  assign is_div = is_div_op(md_sel);
  assign is_mt  = (md_sel == MD_MTHI) || (md_sel == MD_MTLO);
  assign done   = (state == S_RUN) && (cnt == 4'd1);
  assign accept = start && ((state == S_IDLE) || done);

  // An op issued on the completing edge must see the result retiring on that edge.
  assign cur = (done && pend_wr) ? pend : hilo;

  e_md_core u_core (
    .a        (a),
    .b        (b),
    .cur      (cur),
    .md_sel   (md_sel),
    .res      (core_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept && (is_mul || is_div)) next_state = S_RUN;
      S_RUN:  if (done) next_state = (accept && (is_mul || is_div)) ? S_RUN : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hilo    <= '0;
    end else begin
      if (state == S_RUN) cnt <= cnt - 4'd1;
      if (done && pend_wr) hilo <= pend;
      if (accept) begin
        if (is_mul) begin
          cnt     <= 4'(MUL_CYCLES);
          pend    <= core_res;
          pend_wr <= 1'b1;
        end else if (is_div) begin
          cnt     <= 4'(DIV_CYCLES);
          pend    <= core_res;
          pend_wr <= !div_zero;
        end else if (is_mt) begin
          hilo <= core_res;
        end
      end
    end
  end

  assign busy   = (state == S_RUN);
  assign hi_out = hilo.hi;
  assign lo_out = hilo.lo;

endmodule
